// File: rtl/hazard_ctrl.sv
// Stall/flush/forward controller for the 5-stage pipeline, including the
// multiply/divide busy scheduler and a saturating stall-cycle counter.
//
// state | meaning
// IDLE  | MD unit free; a start in E loads the latency counter
// RUN   | MD unit busy; cnt counts down to 1, then returns to IDLE
module hazard_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_D,
  input  logic [4:0]  rt_D,
  input  logic [1:0]  tuse_rs_D,
  input  logic [1:0]  tuse_rt_D,
  input  logic        md_use_D,
  input  logic [4:0]  rs_E,
  input  logic [4:0]  rt_E,
  input  logic [4:0]  a3_E,
  input  logic        regwe_E,
  input  logic [1:0]  tnew_E,
  input  logic [4:0]  a3_M,
  input  logic        regwe_M,
  input  logic [1:0]  tnew_M,
  input  logic [4:0]  a3_W,
  input  logic        regwe_W,
  input  logic        md_start_E,
  input  logic        md_is_div_E,
  output logic        stall,
  output logic        en_F,
  output logic        en_D,
  output logic        flush_E,
  output logic [1:0]  fwd_rs_D,
  output logic [1:0]  fwd_rt_D,
  output logic [1:0]  fwd_rs_E,
  output logic [1:0]  fwd_rt_E,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] stall_cnt
);

  typedef enum logic {IDLE, RUN} md_state_t;

  localparam logic [3:0] MULT_CNT = 4'(MULT_LAT);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT);

  md_state_t  state, state_nxt;
  logic [3:0] cnt, cnt_nxt;

  // Register $0 is hardwired to zero, so it never produces a dependency.
  function automatic logic hit(input logic we, input logic [4:0] a3, input logic [4:0] a);
    return we && (a3 == a) && (a != 5'd0);
  endfunction

  logic rs_hit_E, rs_hit_M, rt_hit_E, rt_hit_M;
  logic stall_data, stall_md;

  assign rs_hit_E = hit(regwe_E, a3_E, rs_D);
  assign rs_hit_M = hit(regwe_M, a3_M, rs_D);
  assign rt_hit_E = hit(regwe_E, a3_E, rt_D);
  assign rt_hit_M = hit(regwe_M, a3_M, rt_D);

  assign stall_data = (rs_hit_E && (tuse_rs_D < tnew_E)) ||
                      (rs_hit_M && (tuse_rs_D < tnew_M)) ||
                      (rt_hit_E && (tuse_rt_D < tnew_E)) ||
                      (rt_hit_M && (tuse_rt_D < tnew_M));

  assign md_busy  = md_start_E || (state == RUN);
  assign md_done  = (state == RUN) && (cnt == 4'd1);
  assign stall_md = md_use_D && md_busy;

  assign stall   = stall_data || stall_md;
  assign en_F    = ~stall;
  assign en_D    = ~stall;
  assign flush_E = stall;

  always_comb begin
    fwd_rs_D = 2'd0;
    fwd_rt_D = 2'd0;
    fwd_rs_E = 2'd0;
    fwd_rt_E = 2'd0;
    if (rs_hit_E && tnew_E == 2'd0)      fwd_rs_D = 2'd1;
    else if (rs_hit_M && tnew_M == 2'd0) fwd_rs_D = 2'd2;
    if (rt_hit_E && tnew_E == 2'd0)      fwd_rt_D = 2'd1;
    else if (rt_hit_M && tnew_M == 2'd0) fwd_rt_D = 2'd2;
    if (hit(regwe_M, a3_M, rs_E) && tnew_M == 2'd0) fwd_rs_E = 2'd1;
    else if (hit(regwe_W, a3_W, rs_E))              fwd_rs_E = 2'd2;
    if (hit(regwe_M, a3_M, rt_E) && tnew_M == 2'd0) fwd_rt_E = 2'd1;
    else if (hit(regwe_W, a3_W, rt_E))              fwd_rt_E = 2'd2;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (md_start_E) begin
          cnt_nxt   = md_is_div_E ? DIV_CNT : MULT_CNT;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (cnt == 4'd1) begin
          cnt_nxt   = 4'd0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: begin
        cnt_nxt   = 4'd0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      stall_cnt <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (stall && stall_cnt != 32'hFFFF_FFFF)
        stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule
